// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array feeder.
package systolic_pkg;

   localparam int DIM                = 3;
   localparam int IDX_W              = 2;
   localparam int DATA_W_DEF         = 8;
   localparam int FEED_CYCLES_DEF    = 8;
   localparam int TIMEOUT_CYCLES_DEF = 16;

   typedef logic [DATA_W_DEF-1:0] elem_t;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      FEED      = 2'd1,
      WAIT_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/skew_lane.sv
// One registered operand lane: emits vec[t-LANE] while feeding, 0 outside the diagonal window.
module skew_lane
   import systolic_pkg::*;
#(
   parameter int W    = DATA_W_DEF,
   parameter int T_W  = 3,
   parameter int LANE = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en_d,
   input  logic [T_W-1:0]        t_d,
   input  logic [DIM-1:0][W-1:0] vec_d,
   output logic [W-1:0]          lane_q
);

   logic [T_W-1:0] k;
   logic [W-1:0]   lane_d;

   always_comb begin
      lane_d = '0;
      k      = t_d - T_W'(LANE);
      if (en_d && (t_d >= T_W'(LANE)) && (k < T_W'(DIM))) begin
         lane_d = vec_d[k[IDX_W-1:0]];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lane_q <= '0;
      end else begin
         lane_q <= lane_d;
      end
   end

endmodule

// File: rtl/systolic_feeder.sv
// Stores 3x3 A/B operands and streams them skewed into the systolic array on go.
// Optional FEEDER_TIMEOUT_EN adds an err pulse when Done never arrives.
module systolic_feeder
   import systolic_pkg::*;
#(
   parameter int DATAWIDTN      = DATA_W_DEF,
   parameter int FEED_CYCLES    = FEED_CYCLES_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 wr_en,
   input  logic                 wr_sel,
   input  logic [IDX_W-1:0]     wr_row,
   input  logic [IDX_W-1:0]     wr_col,
   input  logic [DATAWIDTN-1:0] wr_data,
   input  logic                 go,
   input  logic                 Done,
   output logic                 busy,
   output logic                 feed_done,
   output logic                 start,
   output logic [DATAWIDTN-1:0] A0,
   output logic [DATAWIDTN-1:0] A1,
   output logic [DATAWIDTN-1:0] A2,
   output logic [DATAWIDTN-1:0] B0,
   output logic [DATAWIDTN-1:0] B1,
   output logic [DATAWIDTN-1:0] B2,
   output state_t               dbg_state
`ifdef FEEDER_TIMEOUT_EN
   ,
   output logic                 err
`endif
);

   localparam int T_W = (FEED_CYCLES > 1) ? $clog2(FEED_CYCLES) : 1;
   localparam logic [T_W-1:0] T_LAST = T_W'(FEED_CYCLES - 1);

   typedef logic [DIM-1:0][DIM-1:0][DATAWIDTN-1:0] mat_t;

   state_t         state_q, state_d;
   logic [T_W-1:0] t_q, t_d;
   mat_t           mem_a_q, mem_a_d;
   mat_t           mem_b_q, mem_b_d;
   mat_t           vec_b;
   logic           busy_q, busy_d;
   logic           feed_done_q, feed_done_d;
   logic           start_q, start_d;
   logic [DIM-1:0][DATAWIDTN-1:0] a_lane, b_lane;

`ifdef FEEDER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
`endif

   // Writes land in the _d copy so a same-cycle go feeds the new value.
   always_comb begin
      mem_a_d = mem_a_q;
      mem_b_d = mem_b_q;
      if ((state_q == IDLE) && wr_en && (wr_row < IDX_W'(DIM)) && (wr_col < IDX_W'(DIM))) begin
         if (wr_sel) begin
            mem_b_d[wr_row][wr_col] = wr_data;
         end else begin
            mem_a_d[wr_row][wr_col] = wr_data;
         end
      end
   end

   always_comb begin
      vec_b = '0;
      for (int j = 0; j < DIM; j++) begin
         for (int k = 0; k < DIM; k++) begin
            vec_b[j][k] = mem_b_d[k][j];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      t_d         = t_q;
      feed_done_d = 1'b0;
`ifdef FEEDER_TIMEOUT_EN
      cnt_d       = '0;
      err_d       = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (go) begin
               state_d = FEED;
               t_d     = '0;
            end
         end
         FEED: begin
            if (t_q == T_LAST) begin
               state_d = WAIT_DONE;
               t_d     = '0;
            end else begin
               t_d = t_q + T_W'(1);
            end
         end
         WAIT_DONE: begin
            if (Done) begin
               state_d     = IDLE;
               feed_done_d = 1'b1;
            end
`ifdef FEEDER_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      start_d = (state_d == FEED);
      busy_d  = (state_d != IDLE);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= IDLE;
         t_q         <= '0;
         mem_a_q     <= '0;
         mem_b_q     <= '0;
         busy_q      <= 1'b0;
         feed_done_q <= 1'b0;
         start_q     <= 1'b0;
`ifdef FEEDER_TIMEOUT_EN
         cnt_q       <= '0;
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         t_q         <= t_d;
         mem_a_q     <= mem_a_d;
         mem_b_q     <= mem_b_d;
         busy_q      <= busy_d;
         feed_done_q <= feed_done_d;
         start_q     <= start_d;
`ifdef FEEDER_TIMEOUT_EN
         cnt_q       <= cnt_d;
         err_q       <= err_d;
`endif
      end
   end

   // Lanes see next-cycle t so their registered output lines up with start.
   for (genvar i = 0; i < DIM; i++) begin : g_lane
      skew_lane #(.W(DATAWIDTN), .T_W(T_W), .LANE(i)) u_a (
         .clk    (CLK),
         .rst    (RST),
         .en_d   (start_d),
         .t_d    (t_d),
         .vec_d  (mem_a_d[i]),
         .lane_q (a_lane[i])
      );
      skew_lane #(.W(DATAWIDTN), .T_W(T_W), .LANE(i)) u_b (
         .clk    (CLK),
         .rst    (RST),
         .en_d   (start_d),
         .t_d    (t_d),
         .vec_d  (vec_b[i]),
         .lane_q (b_lane[i])
      );
   end

   assign busy      = busy_q;
   assign feed_done = feed_done_q;
   assign start     = start_q;
   assign dbg_state = state_q;
   assign A0        = a_lane[0];
   assign A1        = a_lane[1];
   assign A2        = a_lane[2];
   assign B0        = b_lane[0];
   assign B1        = b_lane[1];
   assign B2        = b_lane[2];
`ifdef FEEDER_TIMEOUT_EN
   assign err       = err_q;
`endif

endmodule
